// File: rtl/ref_bank_if.sv
// Fill-stream, bank write/read and status bundle
// for the ME reference bank controller.
interface ref_bank_if #(
  parameter int AW = 7,
  parameter int DW = 64
);
  logic          fill_start;
  logic          fill_reject;
  logic          ref_valid;
  logic [DW-1:0] ref_in;
  logic          ref_ready;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          scan_start;
  logic          scan_reject;
  logic          rd_stall;
  logic          rd_en;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic [1:0]    bank_valid;

  modport master (
    output fill_start, ref_valid, ref_in,
    output scan_start, rd_stall,
    input  fill_reject, ref_ready,
    input  wr_en, wr_sel, wr_addr, wr_data,
    input  scan_reject, rd_en, rd_sel,
    input  rd_addr, rd_last, bank_valid
  );

  modport slave (
    input  fill_start, ref_valid, ref_in,
    input  scan_start, rd_stall,
    output fill_reject, ref_ready,
    output wr_en, wr_sel, wr_addr, wr_data,
    output scan_reject, rd_en, rd_sel,
    output rd_addr, rd_last, bank_valid
  );
endinterface

// File: rtl/ref_bank_ctrl.sv
// Ping-pong scheduler: fills one reference bank
// from the fetch stream while the other is scanned.
module ref_bank_ctrl #(
  parameter int ROWS = 128,
  parameter int AW   = 7,
  parameter int DW   = 64
) (
  input  logic      clk,
  input  logic      rst,
  ref_bank_if.slave bus
);
  typedef enum logic [1:0] {
    W_IDLE, W_FILL, W_FLUSH
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE, R_SCAN, R_DONE
  } rstate_t;

  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

  wstate_t       ws;
  rstate_t       rs;
  logic          fsel;
  logic          rsel;
  logic          oldest;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] raddr;
  logic [1:0]    bv;
  logic [1:0]    bv_scan;
  logic [1:0]    bv_nxt;
  logic [1:0]    free;
  logic          wbusy;
  logic          rbusy;

  assign bus.bank_valid = bv;
  assign wbusy = (ws != W_IDLE);
  assign rbusy = (rs != R_IDLE);

  // Bank availability and next valid flags
  always_comb begin
    free[0] = ~bv[0] & ~(wbusy & ~fsel)
            & ~(rbusy & ~rsel);
    free[1] = ~bv[1] & ~(wbusy & fsel)
            & ~(rbusy & rsel);
    bv_scan = bv;
    if (rs == R_DONE) bv_scan[rsel] = 1'b0;
    bv_nxt = bv_scan;
    if (ws == W_FLUSH) bv_nxt[fsel] = 1'b1;
  end

  // Valid flags and fill-age pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bv     <= 2'b00;
      oldest <= 1'b0;
    end else begin
      bv <= bv_nxt;
      if (ws == W_FLUSH && !bv_scan[~fsel])
        oldest <= fsel;
      if (rs == R_DONE && bv_nxt[~rsel])
        oldest <= ~rsel;
    end
  end

  // Write FSM: claim a free bank, store ROWS beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws              <= W_IDLE;
      fsel            <= 1'b0;
      wcnt            <= '0;
      bus.ref_ready   <= 1'b0;
      bus.fill_reject <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_sel      <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
    end else begin
      bus.wr_en       <= 1'b0;
      bus.fill_reject <= 1'b0;
      unique case (ws)
        W_IDLE: begin
          if (bus.fill_start) begin
            if (|free) begin
              fsel          <= ~free[0];
              wcnt          <= '0;
              bus.ref_ready <= 1'b1;
              ws            <= W_FILL;
            end else begin
              bus.fill_reject <= 1'b1;
            end
          end
        end
        W_FILL: begin
          if (bus.ref_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_sel  <= fsel;
            bus.wr_addr <= wcnt;
            bus.wr_data <= bus.ref_in;
            wcnt        <= wcnt + AW'(1);
            if (wcnt == LAST) begin
              bus.ref_ready <= 1'b0;
              ws            <= W_FLUSH;
            end
          end
        end
        W_FLUSH: ws <= W_IDLE;
        default: ws <= W_IDLE;
      endcase
    end
  end

  // Read FSM: scan the oldest valid bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs              <= R_IDLE;
      rsel            <= 1'b0;
      raddr           <= '0;
      bus.scan_reject <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.rd_sel      <= 1'b0;
      bus.rd_addr     <= '0;
      bus.rd_last     <= 1'b0;
    end else begin
      bus.rd_en       <= 1'b0;
      bus.rd_last     <= 1'b0;
      bus.scan_reject <= 1'b0;
      unique case (rs)
        R_IDLE: begin
          if (bus.scan_start) begin
            if (|bv) begin
              rsel  <= (&bv) ? oldest : bv[1];
              raddr <= '0;
              rs    <= R_SCAN;
            end else begin
              bus.scan_reject <= 1'b1;
            end
          end
        end
        R_SCAN: begin
          bus.rd_sel  <= rsel;
          bus.rd_addr <= raddr;
          if (!bus.rd_stall) begin
            bus.rd_en <= 1'b1;
            raddr     <= raddr + AW'(1);
            if (raddr == LAST) begin
              bus.rd_last <= 1'b1;
              rs          <= R_DONE;
            end
          end
        end
        R_DONE: rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_bank_ctrl.sv
// Bench for ref_bank_ctrl: vector table, directed
// sequences and random traffic against a bank model.
module tb_ref_bank_ctrl;
  localparam int ROWS = 128;
  localparam int AW   = 7;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ref_bank_if #(.AW(AW), .DW(DW)) bus ();

  ref_bank_ctrl #(
    .ROWS(ROWS), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cnt_wr, cnt_rd, cnt_last;
  int bad_wsel, bad_rsel;

  // Model: fill/scan progress plus the list of
  // banks holding complete fills, oldest first.
  bit mf_fill, mf_flush, ms_scan, ms_done;
  int mf_sel, ms_sel, mf_k, ms_k;
  int q[$];

  bit e_wr, e_frej, e_srej, e_rd, e_last, e_rdchk;
  int e_wsel, e_rsel, e_waddr, e_raddr;
  logic [DW-1:0] e_wdata;

  typedef struct {
    bit fs, ss, rv;
    bit frej, srej, rdy, wr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  function automatic logic [1:0] model_bv();
    logic [1:0] v = 2'b00;
    foreach (q[i]) v[q[i]] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    mf_fill = 0; mf_flush = 0;
    ms_scan = 0; ms_done = 0;
    mf_sel = 0; ms_sel = 0;
    mf_k = 0; ms_k = 0;
    q.delete();
  endfunction

  task automatic model_edge();
    logic [1:0] bv = model_bv();
    bit f_busy = mf_fill | mf_flush;
    bit s_busy = ms_scan | ms_done;
    bit pre_flush = mf_flush;
    bit pre_done = ms_done;
    bit nf = 0, ns = 0;
    int nf_sel = 0, ns_sel = 0;
    int pick = -1;
    e_wr = 0; e_frej = 0; e_srej = 0;
    e_rd = 0; e_last = 0; e_rdchk = 0;
    if (bus.fill_start && !f_busy) begin
      for (int b = 1; b >= 0; b--)
        if (!bv[b] && !(s_busy && ms_sel == b))
          pick = b;
      if (pick < 0) e_frej = 1;
      else begin nf = 1; nf_sel = pick; end
    end
    if (bus.scan_start && !s_busy) begin
      if (q.size() == 0) e_srej = 1;
      else begin ns = 1; ns_sel = q[0]; end
    end
    if (pre_flush) begin
      q.push_back(mf_sel);
      mf_flush = 0;
    end
    if (pre_done) begin
      void'(q.pop_front());
      ms_done = 0;
    end
    if (mf_fill && bus.ref_valid) begin
      e_wr = 1; e_wsel = mf_sel;
      e_waddr = mf_k; e_wdata = bus.ref_in;
      mf_k++;
      if (mf_k == ROWS) begin
        mf_fill = 0; mf_flush = 1;
      end
    end
    if (ms_scan) begin
      e_rdchk = 1; e_rsel = ms_sel;
      e_raddr = ms_k;
      if (!bus.rd_stall) begin
        e_rd = 1;
        e_last = (ms_k == ROWS - 1);
        ms_k++;
        if (ms_k == ROWS) begin
          ms_scan = 0; ms_done = 1;
        end
      end
    end
    if (nf) begin
      mf_fill = 1; mf_sel = nf_sel; mf_k = 0;
    end
    if (ns) begin
      ms_scan = 1; ms_sel = ns_sel; ms_k = 0;
    end
  endtask

  task automatic check_outputs();
    chk("bank_valid", bus.bank_valid, model_bv());
    chk("ref_ready", bus.ref_ready, mf_fill);
    chk("wr_en", bus.wr_en, e_wr);
    chk("fill_reject", bus.fill_reject, e_frej);
    chk("scan_reject", bus.scan_reject, e_srej);
    chk("rd_en", bus.rd_en, e_rd);
    chk("rd_last", bus.rd_last, e_last);
    if (e_wr) begin
      chk("wr_sel", bus.wr_sel, 64'(e_wsel));
      chk("wr_addr", bus.wr_addr, 64'(e_waddr));
      chk("wr_data", bus.wr_data, e_wdata);
    end
    if (e_rdchk) begin
      chk("rd_sel", bus.rd_sel, 64'(e_rsel));
      chk("rd_addr", bus.rd_addr, 64'(e_raddr));
    end
    if (bus.wr_en) begin
      cnt_wr++;
      if (bus.wr_sel != 1'b1) bad_wsel++;
    end
    if (bus.rd_en) begin
      cnt_rd++;
      if (bus.rd_sel != 1'b0) bad_rsel++;
    end
    if (bus.rd_last) cnt_last++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    bus.fill_start = 0;
    bus.scan_start = 0;
  endtask

  task automatic clr_counts();
    cnt_wr = 0; cnt_rd = 0; cnt_last = 0;
    bad_wsel = 0; bad_rsel = 0;
  endtask

  task automatic clr_inputs();
    bus.fill_start = 0; bus.scan_start = 0;
    bus.ref_valid = 0; bus.ref_in = '0;
    bus.rd_stall = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ref_ready"}, bus.ref_ready, 0);
    chk({nm, ".wr_en"}, bus.wr_en, 0);
    chk({nm, ".wr_sel"}, bus.wr_sel, 0);
    chk({nm, ".wr_addr"}, bus.wr_addr, 0);
    chk({nm, ".wr_data"}, bus.wr_data, 0);
    chk({nm, ".rd_en"}, bus.rd_en, 0);
    chk({nm, ".rd_sel"}, bus.rd_sel, 0);
    chk({nm, ".rd_addr"}, bus.rd_addr, 0);
    chk({nm, ".rd_last"}, bus.rd_last, 0);
    chk({nm, ".bank_valid"}, bus.bank_valid, 0);
    chk({nm, ".fill_reject"}, bus.fill_reject, 0);
    chk({nm, ".scan_reject"}, bus.scan_reject, 0);
  endtask

  // Reset asserted now; outputs must clear at once.
  task automatic hit_reset(input string nm);
    clr_inputs();
    rst = 1'b1;
    #1;
    chk_zero(nm);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_idle(input int stall_pct);
    int n = 0;
    while ((mf_fill || mf_flush || ms_scan || ms_done)
           && n < 2000) begin
      bus.ref_valid = mf_fill;
      bus.rd_stall = ($urandom_range(99) < stall_pct);
      cycle();
      n++;
    end
    clr_inputs();
    if (n >= 2000) timeout("run_idle");
  endtask

  task automatic fill(input logic [7:0] pat);
    int n = 0;
    bus.fill_start = 1;
    cycle();
    while ((mf_fill || mf_flush) && n < 2000) begin
      bus.ref_valid = 1;
      bus.ref_in = {8{pat}};
      cycle();
      n++;
    end
    bus.ref_valid = 0;
    if (n >= 2000) timeout("fill");
  endtask

  task automatic scan();
    bus.scan_start = 1;
    cycle();
    run_idle(0);
  endtask

  initial begin
    int n;
    int stalls;
    #4000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stalls;
    clr_inputs();
    model_reset();
    clr_counts();

    tbl[0] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 0, 0, 1, 1};
    tbl[3] = '{0, 1, 1, 0, 1, 1, 1};
    tbl[4] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 1, 1};
    tbl[6] = '{0, 1, 0, 0, 1, 1, 0};

    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus.fill_start = tbl[i].fs;
      bus.scan_start = tbl[i].ss;
      bus.ref_valid = tbl[i].rv;
      bus.ref_in = {8{8'(i)}};
      cycle();
      chk("tbl.fill_reject", bus.fill_reject,
          tbl[i].frej);
      chk("tbl.scan_reject", bus.scan_reject,
          tbl[i].srej);
      chk("tbl.ref_ready", bus.ref_ready, tbl[i].rdy);
      chk("tbl.wr_en", bus.wr_en, tbl[i].wr);
      chk("tbl.bank_valid", bus.bank_valid, 0);
    end

    n = 0;
    while (mf_k < 60 && n < 200) begin
      bus.ref_valid = 1;
      bus.ref_in = {$urandom, $urandom};
      cycle();
      n++;
    end
    if (n >= 200) timeout("to_beat60");
    hit_reset("mid_fill");

    clr_counts();
    bus.fill_start = 1;
    cycle();
    bus.ref_valid = 1;
    bus.ref_in = {8{8'h0F}};
    cycle();
    chk("refill.wr_addr", bus.wr_addr, 0);
    chk("refill.wr_sel", bus.wr_sel, 0);
    run_idle(0);
    chk("fill0.count", cnt_wr, 128);
    chk("fill0.bank_valid", bus.bank_valid, 2'b01);

    clr_counts();
    stalls = 0;
    bus.scan_start = 1;
    cycle();
    n = 0;
    while ((ms_scan || ms_done) && n < 400) begin
      bus.rd_stall = ms_scan && ms_k == 5 && stalls < 3;
      if (bus.rd_stall) stalls++;
      cycle();
      n++;
    end
    clr_inputs();
    if (n >= 400) timeout("stall_scan");
    chk("stall.rd_count", cnt_rd, 128);
    chk("stall.last_count", cnt_last, 1);
    chk("stall.bank_valid", bus.bank_valid, 2'b00);

    fill(8'h0F);
    clr_counts();
    bus.scan_start = 1;
    fill(8'h55);
    run_idle(0);
    chk("ovl.wr_count", cnt_wr, 128);
    chk("ovl.rd_count", cnt_rd, 128);
    chk("ovl.wr_sel1", bad_wsel, 0);
    chk("ovl.rd_sel0", bad_rsel, 0);
    chk("ovl.bank_valid", bus.bank_valid, 2'b10);

    fill(8'hA5);
    chk("both.bank_valid", bus.bank_valid, 2'b11);
    clr_counts();
    bus.fill_start = 1;
    cycle();
    chk("rej.fill_reject", bus.fill_reject, 1);
    cycle();
    chk("rej.pulse_width", bus.fill_reject, 0);
    chk("rej.no_wr", cnt_wr, 0);

    scan();
    chk("old.first_sel", bus.rd_sel, 1);
    scan();
    chk("old.second_sel", bus.rd_sel, 0);
    fill(8'h11);
    fill(8'h22);
    scan();
    chk("old.third_sel", bus.rd_sel, 0);
    scan();
    chk("old.fourth_sel", bus.rd_sel, 1);

    hit_reset("pre_rand");
    clr_counts();
    bus.scan_start = 1;
    cycle();
    chk("rst.scan_reject", bus.scan_reject, 1);
    cycle();
    chk("rst.no_rd", cnt_rd, 0);

    for (int i = 0; i < 6000; i++) begin
      bus.fill_start = ($urandom_range(15) == 0);
      bus.scan_start = ($urandom_range(15) == 0);
      bus.ref_valid = ($urandom_range(3) != 0);
      bus.ref_in = {$urandom, $urandom};
      bus.rd_stall = ($urandom_range(3) == 0);
      cycle();
      if (i == 3000) hit_reset("rand_rst");
    end
    run_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ref_bank_ctrl.md
Name: ref_bank_ctrl

Overview:
- Ping-pong scheduler for the two 64-bit-wide reference Banks, each ROWS deep, that feed the ME PE array.
- Loads ROWS reference rows from the external fetch stream into one Bank while the other Bank is scanned row by row for the search.
- Tracks which Banks hold valid data, arbitrates fill and scan between them, and generates all Bank write and read controls.

Parameters:
- ROWS, 128, rows per Bank, and beats per fill or scan.
- AW, 7, Bank address width; ROWS <= 2**AW.
- DW, 64, row width (8 pixels x 8 bits).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fill_start  in  1  one-cycle pulse: request a Bank fill.
- fill_reject  out  1  one-cycle pulse: fill_start was refused.
- ref_valid  in  1  fetch stream beat valid.
- ref_in  in  DW  fetch stream row data.
- ref_ready  out  1  controller accepts beats (high only in W_FILL).
- wr_en  out  1  Bank write strobe.
- wr_sel  out  1  target Bank of the write.
- wr_addr  out  AW  write row address.
- wr_data  out  DW  write row data.
- scan_start  in  1  one-cycle pulse: request a Bank scan.
- scan_reject  out  1  one-cycle pulse: scan_start was refused.
- rd_stall  in  1  PE array back-pressure; pauses the scan.
- rd_en  out  1  Bank read strobe.
- rd_sel  out  1  source Bank of the read.
- rd_addr  out  AW  read row address.
- rd_last  out  1  qualifies the final read (rd_addr == ROWS-1).
- bank_valid  out  2  per-Bank "holds a complete fill" flags.

Behaviour:
- Reset: all outputs 0; both FSMs idle; bank_valid = 2'b00; oldest pointer = 0. Reset asserted mid-operation aborts fill and scan immediately. Partially written data is discarded; no flag is set.
- A Bank is free when bank_valid[b] = 0 and b is not the Bank currently being filled or scanned.
- Write FSM states: W_IDLE, W_FILL, W_FLUSH.
  - W_IDLE + fill_start: if a free Bank exists, pick the lowest-index free Bank as fsel, clear the beat count, go to W_FILL. Otherwise pulse fill_reject the next cycle and stay in W_IDLE.
  - W_FILL: ref_ready = 1. Each cycle with ref_valid = 1 accepts one beat.
  - Accepted beat k drives, registered one cycle later: wr_en = 1, wr_sel = fsel, wr_addr = k, wr_data = beat data.
  - After beat ROWS-1 is accepted: drop ref_ready the next cycle and go to W_FLUSH.
  - W_FLUSH: one cycle, the cycle carrying the last wr_en. Then set bank_valid[fsel], set oldest = fsel if the other Bank is not valid, and go to W_IDLE.
  - fill_start outside W_IDLE is ignored, with no reject pulse.
- Read FSM states: R_IDLE, R_SCAN, R_DONE.
  - R_IDLE + scan_start: if some bank_valid bit is 1, pick rsel = the oldest valid Bank (the only one if a single Bank is valid), clear the address, go to R_SCAN. Otherwise pulse scan_reject the next cycle.
  - R_SCAN: registered outputs rd_en = ~rd_stall, rd_sel = rsel, rd_addr = current address. The address increments only on cycles with rd_en = 1.
  - rd_last = 1 together with the rd_en that carries address ROWS-1. That read moves the FSM to R_DONE.
  - R_DONE: one cycle. Clear bank_valid[rsel], flip oldest to the other Bank if it is valid, return to R_IDLE.
  - scan_start outside R_IDLE is ignored.
- Ordering rules:
  - Fill and scan always target different Banks.
  - A Bank freed in R_DONE becomes eligible for fill on the following cycle, not the same cycle.
  - fill_start and scan_start in the same cycle are evaluated independently against registered state.
  - Fill latency: fill_start to first wr_en is at least 2 cycles (1 cycle to W_FILL, 1 cycle register stage).
  - Scan latency: scan_start to first rd_en is 2 cycles with rd_stall = 0.
  - Zero-cycle gaps are allowed between back-to-back fills or scans after the single FLUSH/DONE cycle.

Test Plan:
- Basic fill: reset, fill_start, 128 continuous beats of {8{8'h0F}} -> wr_en high 128 cycles, wr_sel = 0, wr_addr 0..127; bank_valid = 2'b01 one cycle after the last wr_en.
- Scan with stall: scan_start; hold rd_stall = 1 for 3 cycles at addr 5 -> rd_en = 0 for those cycles and rd_addr stays 5; rd_last exactly once at 127; bank_valid returns to 2'b00.
- Overlap: fill Bank 0, then fill_start + scan_start in the same cycle -> scan of Bank 0 and fill of Bank 1 (beats 8'h55) run concurrently; wr_sel = 1, rd_sel = 0 throughout.
- Rejects: both Banks valid, then fill_start -> fill_reject pulse. After reset, scan_start -> scan_reject pulse. In both cases no strobes are issued.
- Oldest-first: fill Bank 0, then Bank 1, then two scans -> the first scan has rd_sel = 0, the second rd_sel = 1.
- Reset mid-fill: assert rst at beat 60 of a fill -> all outputs 0 immediately and bank_valid = 0; a new fill afterwards starts at wr_addr 0 on Bank 0.
